score_ctrl: RTL and testbench



---
 rtl/score_pkg.sv | 24 ++
 rtl/score_ctrl_if.sv | 22 ++
 rtl/vga_frame_tick.sv | 26 ++
 rtl/score_ctrl.sv | 152 +++++++++++++++
 tb/tb_score_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score sequencer: FSM state codes and digit constants.
package score_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_PLAY = ST_PLAY,
    S_HOLD = ST_HOLD,
    S_OVER = ST_OVER
  } state_e;

  localparam logic [3:0] BLANK_CODE = 4'd15;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;

  // Renderer digit: the score itself, or the all-segments-off code when blanked.
  function automatic logic [3:0] digit_out(input logic [3:0] score, input logic blank);
    return blank ? BLANK_CODE : score;
  endfunction

endpackage

// File: rtl/score_ctrl_if.sv
// Game-side bundle of score_ctrl: point/start pulses and vsync in, digits and game status out.
interface score_ctrl_if;
  logic       start;
  logic       point0;
  logic       point1;
  logic       vsync;
  logic [3:0] score0;
  logic [3:0] score1;
  logic       play_en;
  logic       game_over;
  logic       winner;

  modport master (
    output start, point0, point1, vsync,
    input  score0, score1, play_en, game_over, winner
  );

  modport slave (
    input  start, point0, point1, vsync,
    output score0, score1, play_en, game_over, winner
  );
endinterface

// File: rtl/vga_frame_tick.sv
// Synchronises the active-low VGA vsync and emits a one-cycle registered pulse per falling edge.
module vga_frame_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic frame_tick_o
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised sample.
  logic [2:0] sync_q;
  logic       tick_q;

  // Sample vsync and flag a high-to-low transition of the synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], vsync_i};
      tick_q <= sync_q[2] & ~sync_q[1];
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/score_ctrl.sv
// Game-score sequencer: owns both displayed digits, freezes play after each point,
// detects the win and blinks the winner's digit until restart.
module score_ctrl
  import score_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int HOLD_FRAMES  = 60,
  parameter int BLINK_FRAMES = 30
) (
  input logic         clk,
  input logic         rst_n,
  score_ctrl_if.slave bus
);

  localparam logic [3:0] WIN_N   = (WIN_SCORE > int'(MAX_DIGIT)) ? MAX_DIGIT : 4'(WIN_SCORE);
  localparam logic [7:0] HOLD_N  = 8'(HOLD_FRAMES);
  localparam logic [7:0] BLINK_N = 8'(BLINK_FRAMES);

  logic       frame_tick_s;
  state_e     state_q, state_d;
  logic [3:0] sc0_q, sc0_d, sc1_q, sc1_d;
  logic [7:0] hold_q, hold_d, blink_q, blink_d;
  logic       blank_q, blank_d, winner_q, winner_d;
  logic [3:0] score0_q, score1_q;
  logic       play_en_q, game_over_q;
  logic [3:0] new_sc_s;
  logic [3:0] disp0_s, disp1_s;

  vga_frame_tick u_frame_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync_i      (bus.vsync),
    .frame_tick_o (frame_tick_s)
  );

  // Next-state logic for the game FSM, scores and frame counters.
  always_comb begin
    state_d  = state_q;
    sc0_d    = sc0_q;
    sc1_d    = sc1_q;
    hold_d   = hold_q;
    blink_d  = blink_q;
    blank_d  = blank_q;
    winner_d = winner_q;
    new_sc_s = (bus.point1 ? sc1_q : sc0_q) + 4'd1;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PLAY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        // Simultaneous points cancel each other.
        if (bus.point0 ^ bus.point1) begin
          if (bus.point1) begin
            sc1_d = new_sc_s;
          end else begin
            sc0_d = new_sc_s;
          end
          if (new_sc_s == WIN_N) begin
            state_d  = S_OVER;
            winner_d = bus.point1;
            blink_d  = 8'd0;
            blank_d  = 1'b0;
          end else begin
            state_d = S_HOLD;
            hold_d  = 8'd0;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_HOLD: begin
        if (frame_tick_s) begin
          if (hold_q + 8'd1 == HOLD_N) begin
            state_d = S_PLAY;
            hold_d  = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end else begin
          hold_d = hold_q;
        end
      end
      S_OVER: begin
        if (bus.start) begin
          state_d = S_IDLE;
          sc0_d   = 4'd0;
          sc1_d   = 4'd0;
          blink_d = 8'd0;
          blank_d = 1'b0;
        end else if (frame_tick_s) begin
          if (blink_q + 8'd1 == BLINK_N) begin
            blink_d = 8'd0;
            blank_d = ~blank_q;
          end else begin
            blink_d = blink_q + 8'd1;
          end
        end else begin
          blink_d = blink_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Display mux evaluated on next-state values so the outputs can be registered.
  always_comb begin
    disp0_s = digit_out(sc0_d, (state_d == S_OVER) && blank_d && !winner_d);
    disp1_s = digit_out(sc1_d, (state_d == S_OVER) && blank_d && winner_d);
  end

  // Game state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sc0_q       <= 4'd0;
      sc1_q       <= 4'd0;
      hold_q      <= 8'd0;
      blink_q     <= 8'd0;
      blank_q     <= 1'b0;
      winner_q    <= 1'b0;
      score0_q    <= 4'd0;
      score1_q    <= 4'd0;
      play_en_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc0_q       <= sc0_d;
      sc1_q       <= sc1_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
      blank_q     <= blank_d;
      winner_q    <= winner_d;
      score0_q    <= disp0_s;
      score1_q    <= disp1_s;
      play_en_q   <= (state_d == S_PLAY);
      game_over_q <= (state_d == S_OVER);
    end
  end

  assign bus.score0    = score0_q;
  assign bus.score1    = score1_q;
  assign bus.play_en   = play_en_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Self-checking bench for score_ctrl: directed vector table, hand-written multi-frame
// sequences, then randomized play checked against a game-level reference model.
module tb_score_ctrl;

  localparam int WIN   = 9;
  localparam int HOLD  = 60;
  localparam int BLINK = 30;
  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_HOLD = 2;
  localparam int M_OVER = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  score_ctrl_if bus ();

  score_ctrl #(
    .WIN_SCORE    (WIN),
    .HOLD_FRAMES  (HOLD),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: game state in plain terms, plus vsync-edge-to-tick delay line.
  int         m_mode;
  int         m_s[2];
  int         m_win;
  int         m_hold_left;
  int         m_over_ticks;
  logic       m_prev_v;
  logic [2:0] m_d;

  task automatic model_reset();
    m_mode       = M_IDLE;
    m_s[0]       = 0;
    m_s[1]       = 0;
    m_win        = 0;
    m_hold_left  = 0;
    m_over_ticks = 0;
    m_prev_v     = 1'b0;
    m_d          = 3'b000;
  endtask

  task automatic model_edge();
    logic fall;
    logic tick;
    int   who;
    fall     = m_prev_v & ~bus.vsync;
    m_prev_v = bus.vsync;
    tick     = m_d[2];
    m_d      = {m_d[1:0], fall};
    case (m_mode)
      M_IDLE: if (bus.start) m_mode = M_PLAY;
      M_PLAY: begin
        if (bus.point0 != bus.point1) begin
          who = bus.point1 ? 1 : 0;
          m_s[who] = m_s[who] + 1;
          if (m_s[who] == WIN) begin
            m_mode       = M_OVER;
            m_win        = who;
            m_over_ticks = 0;
          end else begin
            m_mode      = M_HOLD;
            m_hold_left = HOLD;
          end
        end
      end
      M_HOLD: begin
        if (tick) begin
          m_hold_left = m_hold_left - 1;
          if (m_hold_left == 0) m_mode = M_PLAY;
        end
      end
      M_OVER: begin
        if (bus.start) begin
          m_mode = M_IDLE;
          m_s[0] = 0;
          m_s[1] = 0;
        end else if (tick) begin
          m_over_ticks = m_over_ticks + 1;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic int model_out();
    bit blank;
    int s0;
    int s1;
    blank = (m_mode == M_OVER) && (((m_over_ticks / BLINK) % 2) == 1);
    s0 = (blank && m_win == 0) ? 15 : m_s[0];
    s1 = (blank && m_win == 1) ? 15 : m_s[1];
    return (s0 << 7) | (s1 << 3) | ((m_mode == M_PLAY ? 1 : 0) << 2)
         | ((m_mode == M_OVER ? 1 : 0) << 1) | m_win;
  endfunction

  function automatic int dut_out();
    return int'({bus.score0, bus.score1, bus.play_en, bus.game_over, bus.winner});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle away from the edge.
  task automatic step(input logic st, input logic p0, input logic p1, input logic v);
    bus.start  = st;
    bus.point0 = p0;
    bus.point1 = p1;
    bus.vsync  = v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic frame();
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic st;
    logic p0;
    logic p1;
    int   s0;
    int   s1;
    int   pe;
    int   go;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int fr_len;
    int fr_pos;
    logic v;
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    bus.start  = 1'b0;
    bus.point0 = 1'b0;
    bus.point1 = 1'b0;
    bus.vsync  = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #2;
    chk("reset_outputs", dut_out(), 0);
    #8 rst_n = 1'b1;

    // {start, point0, point1} -> {score0, score1, play_en, game_over}, vsync held high.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 0, 0, 1, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 0, 0, 1, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 0, 0, 1, 0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 0, 1, 0, 0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 0, 1, 0, 0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 0, 1, 0, 0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 0, 1, 0, 0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].st, tbl[i].p0, tbl[i].p1, 1'b1);
      chk($sformatf("vec%0d", i),
          int'({bus.score0, bus.score1, bus.play_en, bus.game_over}),
          (tbl[i].s0 << 6) | (tbl[i].s1 << 2) | (tbl[i].pe << 1) | tbl[i].go);
    end

    // Hold lasts exactly HOLD frame ticks.
    repeat (HOLD - 1) frame();
    chk("hold_59_frames_play_en", int'(bus.play_en), 0);
    frame();
    chk("hold_60_frames_play_en", int'(bus.play_en), 1);
    chk("hold_score0_kept", int'(bus.score0), 0);
    chk("hold_score1_kept", int'(bus.score1), 1);

    // Player 0 runs to the winning score.
    for (int i = 1; i <= WIN; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("p0_point%0d_score0", i), int'(bus.score0), i);
      if (i < WIN) begin
        chk($sformatf("p0_point%0d_hold", i), int'(bus.play_en), 0);
        repeat (HOLD) frame();
        chk($sformatf("p0_point%0d_resume", i), int'(bus.play_en), 1);
      end
    end
    chk("win_status", int'({bus.play_en, bus.game_over, bus.winner}), 3'b010);
    chk("win_score1", int'(bus.score1), 1);

    // Winner's digit blinks every BLINK frames, loser's stays.
    repeat (BLINK - 1) frame();
    chk("blink_visible_29", int'(bus.score0), 9);
    frame();
    chk("blink_blank_30", int'(bus.score0), 15);
    chk("blink_loser_shown", int'(bus.score1), 1);
    repeat (BLINK) frame();
    chk("blink_visible_60", int'(bus.score0), 9);

    // Restart from OVER, then start again.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("restart_idle", dut_out(), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("restart_play", int'(bus.play_en), 1);

    // Async reset mid-hold with score1 = 4 and a vsync edge in flight.
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (HOLD) frame();
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("pre_reset_score1", int'(bus.score1), 4);
    chk("pre_reset_hold", int'(bus.play_en), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", dut_out(), 0);
    #12 rst_n = 1'b1;
    repeat (70) frame();
    chk("post_reset_idle", dut_out(), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_reset_start", int'(bus.play_en), 1);

    // Randomized play against the reference model.
    do_reset();
    fr_len = 6;
    fr_pos = 0;
    for (int c = 0; c < 20000; c++) begin
      v = (fr_pos < 2) ? 1'b0 : 1'b1;
      fr_pos++;
      if (fr_pos == fr_len) begin
        fr_pos = 0;
        fr_len = $urandom_range(9, 4);
      end
      step($urandom_range(63, 0) == 0, $urandom_range(3, 0) == 0,
           $urandom_range(3, 0) == 0, v);
      chk($sformatf("rand_cycle%0d", c), dut_out(), model_out());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
